// File: rtl/mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Burst read/write controller that owns the address, WE and
//               shared tri-state bus of a 16x16 synchronous memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [3:0]  cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        done,
  output logic [3:0]  mem_address,
  output logic        mem_we,
  inout  wire  [15:0] mem_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WR    = 2'd1,
    S_RD    = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_addr;
  logic [3:0]  r_cnt;
  logic        r_issued;
  logic [15:0] r_rd_data;
  logic        r_rd_valid;
  logic        r_done;

  logic        w_we;

  // Drive the bus only while writing; the memory owns it whenever WE is low.
  assign w_we        = (r_state == S_WR) && wr_valid;
  assign mem_we      = w_we;
  assign mem_bus     = w_we ? wr_data : 16'hzzzz;
  assign mem_address = r_addr;
  assign cmd_ready   = (r_state == S_IDLE);
  assign wr_ready    = (r_state == S_WR);
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign done        = r_done;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_addr     <= 4'd0;
      r_cnt      <= 4'd0;
      r_issued   <= 1'b0;
      r_rd_data  <= 16'd0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      // Memory read data appears one edge after issue; capture it the edge after.
      r_issued <= (r_state == S_RD);
      if (r_issued) begin
        r_rd_data  <= mem_bus;
        r_rd_valid <= 1'b1;
      end else begin
        r_rd_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr  <= cmd_addr;
            r_cnt   <= cmd_len;
            r_state <= cmd_wr ? S_WR : S_RD;
          end
        end
        S_WR: begin
          if (wr_valid) begin
            r_addr <= r_addr + 4'd1;
            if (r_cnt == 4'd0) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
        end
        S_RD: begin
          r_addr <= r_addr + 4'd1;
          if (r_cnt == 4'd0) begin
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DRAIN: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
